demux1t4_32_buf: RTL and testbench
==================================

Name: demux1t4_32_buf

Overview:
- 1-to-4 distributor: routes one 32-bit producer stream to one of four consumer channels, selected by a 2-bit channel code (s=0..3 maps to channel 0..3).
- Each channel has a one-entry output holding register with a valid/ready handshake, so a stalled consumer blocks only its own channel.
- Per-channel saturating transfer counters support debug and the performance display.
- Sits between the CPU-side write path and the peripheral/display sinks.

Parameters:
- W, 32, data width of the input and of each channel.
- CW, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- s  input  2  destination channel for the current input word.
- in_data  input  W  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  distributor accepts the word this cycle.
- o0..o3  output  W each  channel data (holding register contents).
- ov  output  4  per-channel valid; bit k is channel k.
- or_rdy  input  4  per-channel consumer ready; bit k is channel k.
- cnt0..cnt3  output  CW each  saturating count of words delivered on channel k.
- clr_cnt  input  1  synchronous clear of all counters.

Behaviour:
- Reset (rst=1 at a clock edge):
  - ov=0; o0..o3=0; cnt0..cnt3=0.
  - in_ready is driven low combinationally while rst=1.
  - Reset dominates every other input in the same cycle.
  - Reset mid-transfer discards any held words without delivering them.
- Channel k delivers a word when ov[k] & or_rdy[k] at the clock edge.
  - ov[k] clears at that edge unless a new word loads into channel k in the same edge.
- Input acceptance:
  - in_ready = !rst & (!ov[s] | or_rdy[s]); combinational from s, ov and or_rdy.
  - A word is accepted when in_valid & in_ready at the edge.
  - On acceptance, o[s] <= in_data and ov[s] <= 1.
  - Other channels are unaffected.
- Simultaneous deliver and load on the same channel (ov[k]=1, or_rdy[k]=1, accept to k):
  - The old word is delivered, the new word loads, and ov[k] stays 1.
  - Full throughput is 1 word/cycle per channel.
- Blocking: if ov[s]=1 and or_rdy[s]=0, then in_ready=0.
  - The producer must hold s and in_data stable until acceptance.
  - s may change while in_valid=0.
- Channel order is preserved by construction: one entry per channel.
- Latency: an accepted word is visible on o[s], with ov[s]=1, one cycle after acceptance (registered output).
- Data stability: o[k] changes only on a load to channel k. o[k] holds its last value after delivery, while ov[k]=0.
- Counters:
  - cnt[k] increments by 1 on each delivery on channel k.
  - Counters saturate at 2^CW-1; no wrap.
  - clr_cnt=1 zeroes all counters at the edge, overriding a same-cycle increment.
  - Each counter is independent; deliveries on all four channels in one cycle increment all four.
- in_valid=0: no state change except deliveries and counter updates.
- The block is a flat datapath with no FSM beyond the four ov flags. Each channel is effectively a 2-state machine:
  - EMPTY to FULL on load.
  - FULL to EMPTY on delivery without a load.
  - FULL to FULL on delivery with a load, or on a stall.

Test Plan:
- Reset → rst=1 for 2 cycles with in_valid=1, s=2 → ov=4'b0000, in_ready=0, all o and cnt = 0; no load after rst drops until the next accepting edge.
- Basic route → s=1, in_data=32'hDEADBEEF, in_valid=1 for one cycle, or_rdy=4'b0000 → next cycle o1=DEADBEEF, ov=4'b0010, o0/o2/o3 unchanged; then or_rdy[1]=1 → ov=0, cnt1=1.
- Backpressure → channel 3 full, or_rdy[3]=0, s=3, in_valid=1 → in_ready=0 for 5 cycles, o3 unchanged. Switch s=0 → in_ready=1, word loads into o0 while channel 3 stays held.
- Streaming → s=2, or_rdy[2]=1, 10 consecutive words 0..9 with in_valid=1 → in_ready stays 1, o2 shows 0..9 on successive cycles, ov[2]=1 throughout, final cnt2=10.
- Counter saturation/clear → with CW=4, deliver 20 words on channel 0 → cnt0=15. Assert clr_cnt with a simultaneous delivery → cnt0=0.
- Reset mid-operation → ov=4'b1111 with all or_rdy=0, assert rst → ov=0, cnt all 0, no delivery counted.

Source files
------------

// File: rtl/demux1t4_32_buf.sv
// 1-to-4 stream distributor with a one-entry valid/ready holding register per
// channel and per-channel saturating delivery counters.
module demux1t4_32_buf #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    s,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  o0,
  output logic [W-1:0]  o1,
  output logic [W-1:0]  o2,
  output logic [W-1:0]  o3,
  output logic [3:0]    ov,
  input  logic [3:0]    or_rdy,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3,
  input  logic          clr_cnt
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  logic [W-1:0]  data_q [4];
  logic [W-1:0]  data_d [4];
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_d  [4];
  logic [3:0]    ov_q, ov_d;
  logic [3:0]    deliver;
  logic          accept;

  always_comb begin
    in_ready = !rst && (!ov_q[s] || or_rdy[s]);
    accept   = in_valid && in_ready;
    deliver  = ov_q & or_rdy;
    ov_d     = ov_q & ~deliver;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      cnt_d[k]  = cnt_q[k];
      // A load wins over a same-edge delivery so the channel keeps streaming.
      if (accept && (s == 2'(k))) begin
        data_d[k] = in_data;
        ov_d[k]   = 1'b1;
      end
      if (clr_cnt)         cnt_d[k] = '0;
      else if (deliver[k]) cnt_d[k] = sat_inc(cnt_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      ov_q <= ov_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign o0   = data_q[0];
  assign o1   = data_q[1];
  assign o2   = data_q[2];
  assign o3   = data_q[3];
  assign ov   = ov_q;
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux1t4_32_buf.sv
// Directed bench for demux1t4_32_buf (counter width 4 to reach saturation).
module tb_demux1t4_32_buf;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    s;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  o0, o1, o2, o3;
  logic [3:0]    ov;
  logic [3:0]    or_rdy;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
  logic          clr_cnt;

  int tests = 0;
  int fails = 0;

  demux1t4_32_buf #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .s(s), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .o0(o0), .o1(o1), .o2(o2), .o3(o3), .ov(ov),
    .or_rdy(or_rdy), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; s = 2'd2; in_data = 32'hAAAA5555;
    or_rdy = 4'b0000; clr_cnt = 1'b0;
    tick();
    tick();
    tests++; if (ov !== 4'b0000) begin fails++; $display("FAIL reset_ov got=%b exp=0000", ov); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests++; if ({o0, o1, o2, o3} !== 128'd0) begin fails++; $display("FAIL reset_data got=%h %h %h %h exp=0", o0, o1, o2, o3); end
    tests++; if ({cnt0, cnt1, cnt2, cnt3} !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%h exp=0", {cnt0, cnt1, cnt2, cnt3}); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    tests++; if (ov !== 4'b0000 || o2 !== 32'd0) begin fails++; $display("FAIL reset_release got ov=%b o2=%h exp ov=0000 o2=0", ov, o2); end
  endtask

  task automatic test_basic_route();
    s = 2'd1; in_data = 32'hDEADBEEF; in_valid = 1'b1; or_rdy = 4'b0000;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (o1 !== 32'hDEADBEEF || ov !== 4'b0010) begin fails++; $display("FAIL basic_load got o1=%h ov=%b exp DEADBEEF 0010", o1, ov); end
    tests++; if ({o0, o2, o3} !== 96'd0) begin fails++; $display("FAIL basic_others got=%h %h %h exp=0", o0, o2, o3); end
    or_rdy = 4'b0010;
    tick();
    tests++; if (ov !== 4'b0000 || cnt1 !== 4'd1) begin fails++; $display("FAIL basic_deliver got ov=%b cnt1=%0d exp 0000 1", ov, cnt1); end
    tests++; if (o1 !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_hold got=%h exp=DEADBEEF", o1); end
    or_rdy = 4'b0000;
  endtask

  task automatic test_backpressure();
    s = 2'd3; in_data = 32'h33333333; in_valid = 1'b1;
    tick();
    in_data = 32'h44444444;
    for (int i = 0; i < 5; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
      tests++; if (o3 !== 32'h33333333 || ov !== 4'b1000) begin fails++; $display("FAIL bp_hold[%0d] got o3=%h ov=%b exp 33333333 1000", i, o3, ov); end
    end
    in_valid = 1'b0;
    s = 2'd0; in_data = 32'h00C0FFEE; in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_switch_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++; if (o0 !== 32'h00C0FFEE || o3 !== 32'h33333333 || ov !== 4'b1001) begin fails++; $display("FAIL bp_switch got o0=%h o3=%h ov=%b exp 00C0FFEE 33333333 1001", o0, o3, ov); end
    or_rdy = 4'b1001;
    tick();
    tests++; if (ov !== 4'b0000 || cnt0 !== 4'd1 || cnt3 !== 4'd1) begin fails++; $display("FAIL bp_drain got ov=%b cnt0=%0d cnt3=%0d exp 0000 1 1", ov, cnt0, cnt3); end
    or_rdy = 4'b0000;
  endtask

  task automatic test_streaming();
    s = 2'd2; or_rdy = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      in_data = i; in_valid = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      tests++; if (o2 !== i || ov[2] !== 1'b1) begin fails++; $display("FAIL stream_data[%0d] got o2=%0d ov2=%b exp %0d 1", i, o2, ov[2], i); end
    end
    in_valid = 1'b0;
    tick();
    tests++; if (cnt2 !== 4'd10 || ov !== 4'b0000) begin fails++; $display("FAIL stream_cnt got cnt2=%0d ov=%b exp 10 0000", cnt2, ov); end
    or_rdy = 4'b0000;
  endtask

  task automatic test_saturation();
    s = 2'd0; or_rdy = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h100 + i; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tests++; if (cnt0 !== 4'd15) begin fails++; $display("FAIL sat_cnt0 got=%0d exp=15", cnt0); end
    in_data = 32'h0BADF00D; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tests++; if (cnt0 !== 4'd0 || ov !== 4'b0000) begin fails++; $display("FAIL clr_cnt0 got cnt0=%0d ov=%b exp 0 0000", cnt0, ov); end
    tests++; if ({cnt1, cnt2, cnt3} !== 12'd0) begin fails++; $display("FAIL clr_others got=%h exp=0", {cnt1, cnt2, cnt3}); end
    or_rdy = 4'b0000;
  endtask

  task automatic test_reset_mid();
    or_rdy = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k); in_data = 32'h200 + k; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tests++; if (ov !== 4'b1111 || o2 !== 32'h202) begin fails++; $display("FAIL mid_full got ov=%b o2=%h exp 1111 00000202", ov, o2); end
    rst = 1'b1; or_rdy = 4'b1111;
    tick();
    rst = 1'b0;
    tests++; if (ov !== 4'b0000 || {o0, o1, o2, o3} !== 128'd0) begin fails++; $display("FAIL mid_reset got ov=%b o=%h %h %h %h exp 0", ov, o0, o1, o2, o3); end
    tick();
    tests++; if ({cnt0, cnt1, cnt2, cnt3} !== 16'd0 || ov !== 4'b0000) begin fails++; $display("FAIL mid_cnt got cnt=%h ov=%b exp 0 0000", {cnt0, cnt1, cnt2, cnt3}, ov); end
    or_rdy = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_backpressure();
    test_streaming();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
